// File: rtl/proc_pkg.sv
// Shared constants for the proc_top core: widths, opcodes and instruction-field positions.
// Imported by proc_alu and proc_top.
package proc_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 32;
    localparam int GPR_N   = 32;
    localparam int REG_AW  = 5;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0] movsgpr = 5'd0;
    localparam logic [OP_W-1:0] mov     = 5'd1;
    localparam logic [OP_W-1:0] add     = 5'd2;
    localparam logic [OP_W-1:0] sub     = 5'd3;
    localparam logic [OP_W-1:0] mul     = 5'd4;

    localparam int OPER_MSB  = 31;
    localparam int OPER_LSB  = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

endpackage

// File: rtl/proc_if.sv
// Instruction bus of the core: the instruction word going in and the last written GPR value coming out.
// No handshake: din is sampled on every rising clock edge, dout is a plain registered value.
interface proc_if;
    import proc_pkg::*;

    logic [INSTR_W-1:0] din;
    logic [DATA_W-1:0]  dout;

    modport master (output din, input dout);
    modport slave  (input din, output dout);
endinterface

// File: rtl/proc_alu.sv
// Combinational execute stage: result, high product half and write strobes for one opcode.
// The multiplier exists only when PROC_MUL_EN is defined; otherwise opcode 4 is a no-op.
module proc_alu
    import proc_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] high,
    output logic              wr_gpr,
    output logic              wr_sgpr
);

`ifdef PROC_MUL_EN
    logic [2*DATA_W-1:0] product;
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    // The top routes the move source (SGPR, immediate or GPR[rsrc1]) onto b.
    always_comb begin
        result  = '0;
        high    = '0;
        wr_gpr  = 1'b0;
        wr_sgpr = 1'b0;
        case (op)
            movsgpr, mov: begin
                result = b;
                wr_gpr = 1'b1;
            end
            add: begin
                result = a + b;
                wr_gpr = 1'b1;
            end
            sub: begin
                result = a - b;
                wr_gpr = 1'b1;
            end
`ifdef PROC_MUL_EN
            mul: begin
                result  = product[DATA_W-1:0];
                high    = product[2*DATA_W-1:DATA_W];
                wr_gpr  = 1'b1;
                wr_sgpr = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/proc_top.sv
// Single-cycle 16-bit register machine: IR, 32 x 16 GPR file, SGPR and dout register.
// Optional multiplier selected by the PROC_MUL_EN macro (see proc_alu).
module proc_top
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               sys_rst,
    input  logic [INSTR_W-1:0] din,
    output logic [DATA_W-1:0]  dout
);

    logic [INSTR_W-1:0] IR;
    logic [DATA_W-1:0]  GPR [0:GPR_N-1];
    logic [DATA_W-1:0]  SGPR;

    logic [OP_W-1:0]   oper_type;
    logic [REG_AW-1:0] rdst;
    logic [REG_AW-1:0] rsrc1;
    logic [REG_AW-1:0] rsrc2;
    logic              imm_mode;
    logic [DATA_W-1:0] isrc;

    assign oper_type = IR[OPER_MSB:OPER_LSB];
    assign rdst      = IR[RDST_MSB:RDST_LSB];
    assign rsrc1     = IR[RSRC1_MSB:RSRC1_LSB];
    assign rsrc2     = IR[RSRC2_MSB:RSRC2_LSB];
    assign imm_mode  = IR[IMM_BIT];
    assign isrc      = IR[ISRC_MSB:ISRC_LSB];

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_high;
    logic              alu_wr_gpr;
    logic              alu_wr_sgpr;

    assign op_a = GPR[rsrc1];

    // Register moves copy GPR[rsrc1], so that value takes the B slot for mov.
    always_comb begin
        op_b = GPR[rsrc2];
        if (oper_type == movsgpr) begin
            op_b = SGPR;
        end else if (imm_mode) begin
            op_b = isrc;
        end else if (oper_type == mov) begin
            op_b = op_a;
        end
    end

    proc_alu u_alu (
        .op      (oper_type),
        .a       (op_a),
        .b       (op_b),
        .result  (alu_result),
        .high    (alu_high),
        .wr_gpr  (alu_wr_gpr),
        .wr_sgpr (alu_wr_sgpr)
    );

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            IR   <= '0;
            SGPR <= '0;
            dout <= '0;
            for (int i = 0; i < GPR_N; i++) begin
                GPR[i] <= '0;
            end
        end else begin
            IR <= din;
            if (alu_wr_gpr) begin
                GPR[rdst] <= alu_result;
                dout      <= alu_result;
            end
            if (alu_wr_sgpr) begin
                SGPR <= alu_high;
            end
        end
    end

endmodule

// File: tb/tb_proc_top.sv
// Self-checking bench for proc_top: instruction-level reference model, per-cycle compare,
// directed scenarios with literal results and a randomized instruction stream with a mid-stream reset.
module tb_proc_top;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;

    proc_if bus ();

    proc_top dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .din     (bus.din),
        .dout    (bus.dout)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = {5'd7, 27'd0};

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: architectural state at the instruction level.
    logic [31:0] m_ir = '0;
    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr = '0;
    logic [15:0] m_dout = '0;

    logic [4:0]  mo_op, mo_rd, mo_r1, mo_r2;
    logic        mo_im;
    logic [15:0] mo_a, mo_b, mo_isrc;
    logic [31:0] mo_p;

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic im,
                                        input logic [15:0] lo);
        return {op, rd, r1, im, lo};
    endfunction

    always @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            m_ir   = '0;
            m_sgpr = '0;
            m_dout = '0;
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        end else begin
            mo_op   = m_ir[31:27];
            mo_rd   = m_ir[26:22];
            mo_r1   = m_ir[21:17];
            mo_im   = m_ir[16];
            mo_r2   = m_ir[15:11];
            mo_isrc = m_ir[15:0];
            mo_a    = m_gpr[mo_r1];
            mo_b    = mo_im ? mo_isrc : m_gpr[mo_r2];
            case (mo_op)
                5'd0: begin m_gpr[mo_rd] = m_sgpr; m_dout = m_sgpr; end
                5'd1: begin
                    m_gpr[mo_rd] = mo_im ? mo_isrc : mo_a;
                    m_dout       = m_gpr[mo_rd];
                end
                5'd2: begin m_gpr[mo_rd] = 16'((32'(mo_a) + 32'(mo_b)) % 65536); m_dout = m_gpr[mo_rd]; end
                5'd3: begin m_gpr[mo_rd] = 16'((32'(mo_a) + 65536 - 32'(mo_b)) % 65536); m_dout = m_gpr[mo_rd]; end
`ifdef PROC_MUL_EN
                5'd4: begin
                    mo_p         = 32'(mo_a) * 32'(mo_b);
                    m_gpr[mo_rd] = mo_p[15:0];
                    m_sgpr       = mo_p[31:16];
                    m_dout       = mo_p[15:0];
                end
`endif
                default: ;
            endcase
            m_ir = bus.din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of the whole architectural state against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int bad;
            check("cyc_dout", 32'(bus.dout), 32'(m_dout));
            check("cyc_sgpr", 32'(dut.SGPR), 32'(m_sgpr));
            check("cyc_ir", dut.IR, m_ir);
            bad = -1;
            for (int i = 0; i < 32; i++) begin
                if (dut.GPR[i] !== m_gpr[i] && bad < 0) bad = i;
            end
            n_total++;
            if (bad < 0) n_pass++;
            else $display("FAIL cyc_gpr[%0d]: got %h expected %h at %0t",
                          bad, dut.GPR[bad], m_gpr[bad], $time);
        end
    end

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        bus.din = w;
    endtask

    // Present one instruction and return once its result is architecturally visible.
    task automatic exec(input logic [31:0] w);
        issue(w);
        issue(NOP);
        @(negedge clk);
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) issue(ins(5'd1, 5'(i), 5'd0, 1'b1, 16'd2));
        issue(NOP);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) if (dut.GPR[i] !== 16'd0) ok = 1'b0;
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s_gpr: got nonzero register expected all zero", tag);
        check({tag, "_ir"}, dut.IR, 32'd0);
        check({tag, "_sgpr"}, 32'(dut.SGPR), 32'd0);
        check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    endtask

    initial begin
        logic [4:0]  r_op;
        logic [15:0] r_lo;

        bus.din = '0;
        #2 sys_rst = 1'b0;
        #1 check_all_zero("rst0");
        @(negedge clk);
        sys_rst = 1'b1;
        chk_en  = 1'b1;

        // Add
        preload();
        exec(ins(5'd2, 5'd0, 5'd2, 1'b1, 16'd4));
        check("add_imm_gpr0", 32'(dut.GPR[0]), 32'd6);
        check("add_imm_dout", 32'(bus.dout), 32'd6);
        exec(ins(5'd2, 5'd0, 5'd4, 1'b0, {5'd5, 11'd0}));
        check("add_reg_gpr0", 32'(dut.GPR[0]), 32'd4);

        // Move
        preload();
        exec(ins(5'd1, 5'd4, 5'd0, 1'b1, 16'd55));
        check("mov_imm_gpr4", 32'(dut.GPR[4]), 32'd55);
        exec(ins(5'd1, 5'd4, 5'd7, 1'b0, 16'd0));
        check("mov_reg_gpr4", 32'(dut.GPR[4]), 32'd2);

        // Multiply and SGPR
        preload();
`ifdef PROC_MUL_EN
        exec(ins(5'd4, 5'd0, 5'd2, 1'b1, 16'd4));
        check("mul_imm_gpr0", 32'(dut.GPR[0]), 32'd8);
        check("mul_imm_sgpr", 32'(dut.SGPR), 32'd0);
        exec(ins(5'd4, 5'd2, 5'd0, 1'b0, {5'd1, 11'd0}));
        check("mul_reg_gpr2", 32'(dut.GPR[2]), 32'd16);
        exec(ins(5'd0, 5'd3, 5'd0, 1'b0, 16'd0));
        check("movsgpr_gpr3", 32'(dut.GPR[3]), 32'd0);

        exec(ins(5'd1, 5'd1, 5'd0, 1'b1, 16'hFFFF));
        exec(ins(5'd4, 5'd5, 5'd1, 1'b1, 16'h0010));
        check("mul_ovf_gpr5", 32'(dut.GPR[5]), 32'h0000_FFF0);
        check("mul_ovf_sgpr", 32'(dut.SGPR), 32'h0000_000F);
        exec(ins(5'd0, 5'd6, 5'd0, 1'b0, 16'd0));
        check("movsgpr_gpr6", 32'(dut.GPR[6]), 32'h0000_000F);
`else
        exec(ins(5'd4, 5'd0, 5'd2, 1'b1, 16'd4));
        check("nomul_gpr0", 32'(dut.GPR[0]), 32'd2);
        check("nomul_sgpr", 32'(dut.SGPR), 32'd0);
        check("nomul_dout", 32'(bus.dout), 32'd2);
`endif

        // Subtract wrap and an unused opcode
        preload();
        exec(ins(5'd1, 5'd1, 5'd0, 1'b1, 16'd3));
        exec(ins(5'd3, 5'd8, 5'd1, 1'b1, 16'd5));
        check("sub_wrap_gpr8", 32'(dut.GPR[8]), 32'h0000_FFFE);
        check("sub_wrap_dout", 32'(bus.dout), 32'h0000_FFFE);
        exec(ins(5'd7, 5'd8, 5'd1, 1'b1, 16'h1234));
        check("op7_gpr8", 32'(dut.GPR[8]), 32'h0000_FFFE);
        check("op7_dout", 32'(bus.dout), 32'h0000_FFFE);

        // Randomized stream with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                @(posedge clk);
                #2 sys_rst = 1'b0;
                #1 check_all_zero("rst_mid");
                @(posedge clk);
                @(negedge clk);
                sys_rst = 1'b1;
            end
            r_op = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) r_op = 5'($urandom_range(5, 31));
            r_lo = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_lo = 16'hFFFF - 16'($urandom_range(0, 3));
            issue(ins(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), r_lo));
        end
        issue(NOP);
        issue(NOP);
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
